// File: rtl/async_fifo_wr_ctrl.sv
// -----------------------------------------------------------------------------
// async_fifo_wr_ctrl
//
// Write-side pointer and flag controller of a dual-clock FIFO. Everything here
// runs on wr_clk. The dual-port RAM and the read-side controller sit beside
// this block.
//
// The block owns the binary write pointer and a registered Gray copy of it,
// which is exported to the read domain. It brings the read domain's Gray
// pointer into wr_clk through two flops and converts it back to binary. From
// the write pointer and that synchronised read pointer it derives:
//   - full
//   - prog_full
//   - a fill count
//   - a sticky overflow flag
//
// Pointers are RAM_ADDR_WIDTH bits wide. The extra MSB is a wrap bit, so the
// FIFO depth is 2**(RAM_ADDR_WIDTH-1).
//
// Ports
//   wr_clk       in   write clock, the only clock
//   wr_rst_n     in   synchronous reset, active low
//   wr_en        in   write request from user logic
//   rdaddr_gray  in   read pointer (Gray), registered in the rd_clk domain
//   wraddr       out  binary write pointer. The RAM address is
//                     wraddr[RAM_ADDR_WIDTH-2:0]
//   wraddr_gray  out  registered Gray copy of wraddr, to the read side
//   wr_ram_en    out  RAM write strobe (combinational)
//   full         out  FIFO full as seen from the write domain
//   prog_full    out  fill level >= PROG_FULL_THRESH
//   elements_wr  out  fill count, 0..DEPTH
//   overflow     out  sticky: wr_en seen while full, cleared only by reset
// -----------------------------------------------------------------------------
module async_fifo_wr_ctrl #(
  parameter int RAM_ADDR_WIDTH   = 8,
  parameter int PROG_FULL_THRESH = 126
) (
  input  logic                      wr_clk,
  input  logic                      wr_rst_n,
  input  logic                      wr_en,
  input  logic [RAM_ADDR_WIDTH-1:0] rdaddr_gray,
  output logic [RAM_ADDR_WIDTH-1:0] wraddr,
  output logic [RAM_ADDR_WIDTH-1:0] wraddr_gray,
  output logic                      wr_ram_en,
  output logic                      full,
  output logic                      prog_full,
  output logic [RAM_ADDR_WIDTH-1:0] elements_wr,
  output logic                      overflow
);

  localparam int W = RAM_ADDR_WIDTH;

  localparam logic [W-1:0] PF_THRESH = W'(PROG_FULL_THRESH);

  // ---------------------------------------------------------------------------
  // Gray code helpers
  // ---------------------------------------------------------------------------
  function automatic logic [W-1:0] bin2gray(input logic [W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at and above its position.
  function automatic logic [W-1:0] gray2bin(input logic [W-1:0] g);
    logic [W-1:0] b;
    b[W-1] = g[W-1];
    for (int i = W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [W-1:0] wraddr_q,      wraddr_d;
  logic [W-1:0] wraddr_gray_q, wraddr_gray_d;
  logic [W-1:0] rd_gray_ff1_q;
  logic [W-1:0] rd_gray_ff2_q;
  logic         overflow_q,    overflow_d;

  logic [W-1:0] sync_rdaddr;
  logic [W-1:0] fill_count;
  logic         full_int;
  logic         write_ok;

  // ---------------------------------------------------------------------------
  // Flags
  //
  // The flags are built only from flops (the write pointer and the second sync
  // stage). They therefore carry no combinational path from the asynchronous
  // input. They are pessimistic: a read becomes visible here two edges late,
  // which can only make the FIFO look fuller than it really is.
  // ---------------------------------------------------------------------------
  assign sync_rdaddr = gray2bin(rd_gray_ff2_q);

  // Full means the pointers are one lap apart: the wrap bits differ and the
  // RAM address bits are equal.
  assign full_int = (wraddr_q[W-1] != sync_rdaddr[W-1]) &&
                    (wraddr_q[W-2:0] == sync_rdaddr[W-2:0]);

  // The subtraction is modulo 2**W. Because the pointers carry a wrap bit, the
  // result is correct across a wrap and reaches DEPTH exactly when full.
  assign fill_count = wraddr_q - sync_rdaddr;

  // A write in the reset cycle is dropped, so the RAM strobe is gated too.
  assign write_ok = wr_en && !full_int && wr_rst_n;

  // ---------------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    wraddr_d   = wraddr_q;
    overflow_d = overflow_q;

    if (wr_en && !full_int) begin
      wraddr_d = wraddr_q + 1'b1;
    end

    if (wr_en && full_int) begin
      overflow_d = 1'b1;
    end

    // The Gray copy is computed from the *next* binary pointer. This keeps it
    // registered (glitch-free for the other domain) and in step with wraddr.
    wraddr_gray_d = bin2gray(wraddr_d);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: state updates use non-blocking assignments, so every flop samples the
  // pre-edge value of the others. The two sync stages therefore form a real
  // two-flop chain rather than collapsing into one.
  //
  // NOTE: the synchroniser flops are reset along with the pointer. After reset
  // the flags then see an empty FIFO at once instead of waiting for the
  // read-side pointer to be shifted in.
  always_ff @(posedge wr_clk) begin
    if (!wr_rst_n) begin
      wraddr_q      <= '0;
      wraddr_gray_q <= '0;
      rd_gray_ff1_q <= '0;
      rd_gray_ff2_q <= '0;
      overflow_q    <= 1'b0;
    end else begin
      wraddr_q      <= wraddr_d;
      wraddr_gray_q <= wraddr_gray_d;
      rd_gray_ff1_q <= rdaddr_gray;
      rd_gray_ff2_q <= rd_gray_ff1_q;
      overflow_q    <= overflow_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign wraddr      = wraddr_q;
  assign wraddr_gray = wraddr_gray_q;
  assign wr_ram_en   = write_ok;
  assign full        = full_int;
  assign elements_wr = fill_count;
  assign prog_full   = (fill_count >= PF_THRESH);
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_async_fifo_wr_ctrl.sv
// -----------------------------------------------------------------------------
// tb_async_fifo_wr_ctrl
//
// Directed bench for the write-side FIFO controller.
//
// The read pointer is modelled in binary (m_rp) and driven to the DUT as Gray.
// The bench keeps its own two-stage binary delay line for that pointer. The
// expected fill level is simply write count minus delayed read count, and full
// means that level equals DEPTH.
//
// Each step does three things:
//   1. Checks wr_ram_en before the edge.
//   2. Pushes the expected post-edge outputs to a queue.
//   3. Pops that entry and compares it against the DUT one time unit after the
//      edge.
// -----------------------------------------------------------------------------
module tb_async_fifo_wr_ctrl;

  localparam int W     = 8;
  localparam int DEPTH = 128;
  localparam int PFT   = 126;

  logic         wr_clk = 1'b0;
  logic         wr_rst_n;
  logic         wr_en;
  logic [W-1:0] rdaddr_gray;
  logic [W-1:0] wraddr;
  logic [W-1:0] wraddr_gray;
  logic         wr_ram_en;
  logic         full;
  logic         prog_full;
  logic [W-1:0] elements_wr;
  logic         overflow;

  async_fifo_wr_ctrl #(
    .RAM_ADDR_WIDTH  (W),
    .PROG_FULL_THRESH(PFT)
  ) dut (
    .wr_clk     (wr_clk),
    .wr_rst_n   (wr_rst_n),
    .wr_en      (wr_en),
    .rdaddr_gray(rdaddr_gray),
    .wraddr     (wraddr),
    .wraddr_gray(wraddr_gray),
    .wr_ram_en  (wr_ram_en),
    .full       (full),
    .prog_full  (prog_full),
    .elements_wr(elements_wr),
    .overflow   (overflow)
  );

  always #5 wr_clk = ~wr_clk;

  typedef struct packed {
    logic [W-1:0] wa;
    logic [W-1:0] wg;
    logic [W-1:0] cnt;
    logic         full;
    logic         pf;
    logic         ovf;
  } exp_t;

  exp_t sb_q[$];

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state
  logic [W-1:0] m_wa;   // write pointer (binary)
  logic [W-1:0] m_rp;   // read pointer as driven (binary)
  logic [W-1:0] m_s1;   // first sync stage (binary)
  logic [W-1:0] m_s2;   // second sync stage (binary)
  logic         m_ovf;

  logic [W-1:0] prev_wa;
  logic [W-1:0] prev_wg;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s at %0t: observed 0x%0h expected 0x%0h",
             tag, $time, obs, exp);
    end
  endtask

  task automatic step(input logic rst_n, input logic en);
    logic [W-1:0] level;
    logic         full_now;
    exp_t         e;
    exp_t         got;

    // Drive inputs for this cycle.
    wr_rst_n    = rst_n;
    wr_en       = en;
    rdaddr_gray = m_rp ^ (m_rp >> 1);
    #1;

    // The RAM strobe is combinational, so check it before the edge.
    level    = m_wa - m_s2;
    full_now = (level == W'(DEPTH));
    check("wr_ram_en", {31'd0, wr_ram_en}, {31'd0, en & ~full_now & rst_n});

    // Advance the model across the coming edge.
    if (!rst_n) begin
      m_wa  = '0;
      m_s1  = '0;
      m_s2  = '0;
      m_ovf = 1'b0;
    end else begin
      if (en && full_now) m_ovf = 1'b1;
      if (en && !full_now) m_wa = m_wa + 1'b1;
      m_s2 = m_s1;
      m_s1 = m_rp;
    end

    level  = m_wa - m_s2;
    e.wa   = m_wa;
    e.wg   = m_wa ^ (m_wa >> 1);
    e.cnt  = level;
    e.full = (level == W'(DEPTH));
    e.pf   = (int'(level) >= PFT);
    e.ovf  = m_ovf;
    sb_q.push_back(e);

    @(posedge wr_clk);
    #1;

    got = sb_q.pop_front();
    check("wraddr",      {24'd0, wraddr},      {24'd0, got.wa});
    check("wraddr_gray", {24'd0, wraddr_gray}, {24'd0, got.wg});
    check("elements_wr", {24'd0, elements_wr}, {24'd0, got.cnt});
    check("full",        {31'd0, full},        {31'd0, got.full});
    check("prog_full",   {31'd0, prog_full},   {31'd0, got.pf});
    check("overflow",    {31'd0, overflow},    {31'd0, got.ovf});
  endtask

  // Watchdog: the bench must always end by itself.
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    wr_rst_n    = 1'b0;
    wr_en       = 1'b0;
    rdaddr_gray = '0;
    m_wa        = '0;
    m_rp        = '0;
    m_s1        = '0;
    m_s2        = '0;
    m_ovf       = 1'b0;
    @(posedge wr_clk);
    #1;

    // 1. Reset, then fill 128 entries. Write 129 is blocked.
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    repeat (DEPTH) step(1'b1, 1'b1);
    check("t1_full_after_128", {31'd0, full}, 32'd1);
    check("t1_wraddr_128", {24'd0, wraddr}, 32'd128);
    step(1'b1, 1'b1);

    // 2. Keep pushing while full. Overflow sticks until reset.
    repeat (2) step(1'b1, 1'b1);
    repeat (3) step(1'b1, 1'b0);
    check("t2_ovf_sticky", {31'd0, overflow}, 32'd1);
    step(1'b0, 1'b0);
    check("t2_ovf_cleared", {31'd0, overflow}, 32'd0);

    // 3. Full, then a read. Full drops two edges later, then one write
    //    refills the FIFO.
    repeat (DEPTH) step(1'b1, 1'b1);
    m_rp = 8'd1;
    step(1'b1, 1'b0);
    check("t3_full_t1", {31'd0, full}, 32'd1);
    step(1'b1, 1'b0);
    check("t3_full_t2", {31'd0, full}, 32'd0);
    check("t3_count_127", {24'd0, elements_wr}, 32'd127);
    step(1'b1, 1'b1);
    check("t3_refill", {31'd0, full}, 32'd1);

    // 4. prog_full threshold, crossed upward and then downward.
    m_rp = '0;
    step(1'b0, 1'b0);
    repeat (PFT - 1) step(1'b1, 1'b1);
    check("t4_pf_125", {31'd0, prog_full}, 32'd0);
    step(1'b1, 1'b1);
    check("t4_pf_126", {31'd0, prog_full}, 32'd1);
    m_rp = 8'd1;
    step(1'b1, 1'b0);
    check("t4_pf_lag", {31'd0, prog_full}, 32'd1);
    step(1'b1, 1'b0);
    check("t4_pf_drop", {31'd0, prog_full}, 32'd0);

    // 5. Stream across the pointer wrap with a trailing reader.
    m_rp = '0;
    step(1'b0, 1'b0);
    for (int i = 0; i < 300; i++) begin
      prev_wa = wraddr;
      prev_wg = wraddr_gray;
      if (8'(m_wa - m_s2) >= 8'd64) m_rp = m_rp + 1'b1;
      step(1'b1, 1'b1);
      check("t5_gray_one_bit", $countones(prev_wg ^ wraddr_gray), 32'd1);
      if (prev_wa == 8'hFF) begin
        check("t5_wrap_prev_gray", {24'd0, prev_wg}, 32'h80);
        check("t5_wrap_gray", {24'd0, wraddr_gray}, 32'h00);
        check("t5_wrap_bin", {24'd0, wraddr}, 32'h00);
      end
    end

    // 6. Reset asserted mid-operation with wr_en high.
    m_rp = '0;
    step(1'b0, 1'b0);
    repeat (60) step(1'b1, 1'b1);
    check("t6_count_60", {24'd0, elements_wr}, 32'd60);
    step(1'b0, 1'b1);
    check("t6_wraddr_0", {24'd0, wraddr}, 32'd0);
    check("t6_gray_0", {24'd0, wraddr_gray}, 32'd0);
    step(1'b1, 1'b0);

    check("sb_empty", sb_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
